// File: rtl/axi4_pkg.sv
// axi4_pkg: AXI4 response/burst encodings, default ARCACHE and the read-arbiter FSM states.
package axi4_pkg;
    typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} resp_t;
    typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP} burst_t;
    localparam logic [3:0] ARCACHE_DEFAULT = 4'b0011;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after the pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);
    localparam int IW = $clog2(NUM_REQ);
    logic [IW-1:0] w_j;
    // Walk from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_j     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (i_req[w_j]) begin
                o_grant = NUM_REQ'(1) << w_j;
                o_idx   = w_j;
            end
        end
    end
endmodule

// File: rtl/axi4_read_arbiter.sv
// axi4_read_arbiter: round-robin share of one AXI4 read master among NUM_REQ requesters,
// one burst outstanding, R beats steered back to the granted requester until RLAST.
module axi4_read_arbiter
    import axi4_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ADDR_LSB   = $clog2(AXI_STRB_WIDTH)
) (
    input  logic                                M_AXI_ACLK,
    input  logic                                M_AXI_ARESET,
    input  logic [NUM_REQ-1:0]                  REQ_ARVALID,
    output logic [NUM_REQ-1:0]                  REQ_ARREADY,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]   REQ_ARADDR,
    input  logic [NUM_REQ*8-1:0]                REQ_ARLEN,
    output logic [AXI_DATA_WIDTH-1:0]           REQ_RDATA,
    output logic [1:0]                          REQ_RRESP,
    output logic                                REQ_RLAST,
    output logic [NUM_REQ-1:0]                  REQ_RVALID,
    input  logic [NUM_REQ-1:0]                  REQ_RREADY,
    output logic [AXI_ID_WIDTH-1:0]             M_AXI_ARID,
    output logic [AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
    output logic [7:0]                          M_AXI_ARLEN,
    output logic [2:0]                          M_AXI_ARSIZE,
    output logic [1:0]                          M_AXI_ARBURST,
    output logic                                M_AXI_ARLOCK,
    output logic [3:0]                          M_AXI_ARCACHE,
    output logic [2:0]                          M_AXI_ARPROT,
    output logic [3:0]                          M_AXI_ARQOS,
    output logic [3:0]                          M_AXI_ARREGION,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    input  logic [AXI_ID_WIDTH-1:0]             M_AXI_RID,
    input  logic [AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RLAST,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY,
    output logic                                ERR_RID
);
    localparam int IW = $clog2(NUM_REQ);
    state_t                    r_state;
    logic [IW-1:0]             r_ptr;
    logic [IW-1:0]             r_grant;
    logic                      r_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                r_arlen;
    logic                      r_err;
    logic [NUM_REQ-1:0]        w_gnt_oh;
    logic [IW-1:0]             w_gnt_idx;
    logic                      w_in_idle;
    logic                      w_in_data;
    logic                      w_rhs;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (REQ_ARVALID),
        .i_ptr   (r_ptr),
        .o_grant (w_gnt_oh),
        .o_idx   (w_gnt_idx)
    );
    assign w_in_idle      = r_state == ST_IDLE;
    assign w_in_data      = r_state == ST_DATA;
    assign w_rhs          = M_AXI_RVALID && M_AXI_RREADY;
    assign REQ_ARREADY    = w_in_idle ? w_gnt_oh : '0;
    assign M_AXI_RREADY   = w_in_data && REQ_RREADY[r_grant];
    assign REQ_RVALID     = (w_in_data && M_AXI_RVALID) ? NUM_REQ'(1) << r_grant : '0;
    assign REQ_RDATA      = M_AXI_RDATA;
    assign REQ_RRESP      = M_AXI_RRESP;
    assign REQ_RLAST      = M_AXI_RLAST;
    assign M_AXI_ARID     = AXI_ID_WIDTH'(r_grant);
    assign M_AXI_ARADDR   = r_araddr;
    assign M_AXI_ARLEN    = r_arlen;
    assign M_AXI_ARVALID  = r_arvalid;
    assign M_AXI_ARSIZE   = 3'(AXI_ADDR_LSB);
    assign M_AXI_ARBURST  = BURST_INCR;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = ARCACHE_DEFAULT;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARQOS    = 4'd0;
    assign M_AXI_ARREGION = 4'd0;
    assign ERR_RID        = r_err;
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (|REQ_ARVALID) begin
                    r_grant   <= w_gnt_idx;
                    r_araddr  <= REQ_ARADDR[w_gnt_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    r_arlen   <= REQ_ARLEN[w_gnt_idx*8 +: 8];
                    r_ptr     <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
                    r_arvalid <= 1'b1;
                    r_state   <= ST_ADDR;
                end
                ST_ADDR: if (M_AXI_ARREADY) begin
                    r_arvalid <= 1'b0;
                    r_state   <= ST_DATA;
                end
                ST_DATA: if (w_rhs && M_AXI_RLAST) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            // A wrong RID is flagged but the beat is still delivered.
            if (w_rhs && M_AXI_RID != AXI_ID_WIDTH'(r_grant)) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi4_read_arbiter.sv
// tb_axi4_read_arbiter: directed and randomized bursts against a round-robin/one-burst reference model.
module tb_axi4_read_arbiter;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] REQ_ARVALID, REQ_ARREADY, REQ_RVALID, REQ_RREADY;
    logic [N*32-1:0] REQ_ARADDR;
    logic [N*8-1:0] REQ_ARLEN;
    logic [31:0] REQ_RDATA;
    logic [1:0] REQ_RRESP;
    logic REQ_RLAST;
    logic [3:0] M_AXI_ARID, M_AXI_ARCACHE, M_AXI_ARQOS, M_AXI_ARREGION, M_AXI_RID;
    logic [31:0] M_AXI_ARADDR, M_AXI_RDATA;
    logic [7:0] M_AXI_ARLEN;
    logic [2:0] M_AXI_ARSIZE, M_AXI_ARPROT;
    logic [1:0] M_AXI_ARBURST, M_AXI_RRESP;
    logic M_AXI_ARLOCK, M_AXI_ARVALID, M_AXI_ARREADY, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY, ERR_RID;
    logic [31:0] addr_q [N];
    logic [7:0] len_q [N];
    int ptr_m, n_chk, n_fail;
    bit err_m;
    int g;
    logic [31:0] ea;
    logic [7:0] el;
    assign REQ_ARADDR = {addr_q[1], addr_q[0]};
    assign REQ_ARLEN  = {len_q[1], len_q[0]};
    always #5 clk = ~clk;
    axi4_read_arbiter dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
        .REQ_ARVALID(REQ_ARVALID), .REQ_ARREADY(REQ_ARREADY), .REQ_ARADDR(REQ_ARADDR), .REQ_ARLEN(REQ_ARLEN),
        .REQ_RDATA(REQ_RDATA), .REQ_RRESP(REQ_RRESP), .REQ_RLAST(REQ_RLAST), .REQ_RVALID(REQ_RVALID),
        .REQ_RREADY(REQ_RREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
        .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
        .M_AXI_ARREGION(M_AXI_ARREGION), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .ERR_RID(ERR_RID)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic idle_chk();
        chk("idle_arvalid", M_AXI_ARVALID, 0);
        chk("idle_m_rready", M_AXI_RREADY, 0);
        chk("idle_req_rvalid", REQ_RVALID, 0);
        chk("err_rid", ERR_RID, err_m);
    endtask
    // drop: 0 keep requests, 1 drop the granted requester, 2 drop all
    task automatic grant_phase(input int drop, output int e, output logic [31:0] a, output logic [7:0] l);
        int j;
        e = -1;
        for (int k = 0; k < N; k++) begin
            j = (ptr_m + k) % N;
            if (REQ_ARVALID[j]) begin
                e = j;
                break;
            end
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            idle_chk();
            if (REQ_ARREADY != 0) break;
            @(posedge clk); #1;
        end
        chk("arready_grant", REQ_ARREADY, (e < 0) ? 0 : 64'(1) << e);
        a = addr_q[e];
        l = len_q[e];
        ptr_m = (e + 1) % N;
        @(posedge clk); #1;
        if (drop == 1) REQ_ARVALID[e] = 1'b0;
        if (drop == 2) REQ_ARVALID = '0;
    endtask
    task automatic addr_phase(input int e, input int delay, input logic [31:0] a, input logic [7:0] l);
        addr_q[e] = $urandom;
        M_AXI_ARREADY = (delay == 0);
        @(negedge clk);
        chk("arvalid", M_AXI_ARVALID, 1);
        chk("araddr", M_AXI_ARADDR, a);
        chk("arlen", M_AXI_ARLEN, l);
        chk("arid", M_AXI_ARID, e);
        chk("arsize", M_AXI_ARSIZE, 2);
        chk("arburst", M_AXI_ARBURST, 1);
        chk("arcache", M_AXI_ARCACHE, 4'b0011);
        chk("ar_zero_fields", {M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARREGION}, 0);
        chk("arready_in_addr", REQ_ARREADY, 0);
        for (int i = 1; i <= delay; i++) begin
            @(posedge clk); #1;
            if (i == delay) M_AXI_ARREADY = 1'b1;
            @(negedge clk);
            chk("arvalid_held", M_AXI_ARVALID, 1);
            chk("araddr_stable", M_AXI_ARADDR, a);
            chk("arlen_stable", M_AXI_ARLEN, l);
        end
        @(posedge clk); #1;
        M_AXI_ARREADY = 1'b0;
    endtask
    task automatic data_phase(input int e, input int len, input int nsend, input bit tog, input bit bad,
                              input logic [1:0] resp, input logic [31:0] base);
        int b = 0;
        int cyc = 0;
        bit rr = 1'b1;
        logic [31:0] d;
        d = (base != 0) ? base : $urandom;
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA = d;
        M_AXI_RID = bad ? 4'(1 - e) : 4'(e);
        M_AXI_RRESP = resp;
        M_AXI_RLAST = (len == 0);
        REQ_RREADY[e] = rr;
        REQ_RREADY[1-e] = ~rr;
        while (b < nsend && cyc < 100) begin
            @(negedge clk);
            chk("req_rvalid", REQ_RVALID, 64'(1) << e);
            chk("m_rready_mirror", M_AXI_RREADY, rr);
            chk("rdata", REQ_RDATA, d);
            chk("rresp", REQ_RRESP, resp);
            chk("rlast", REQ_RLAST, b == len);
            chk("arvalid_in_data", M_AXI_ARVALID, 0);
            chk("err_rid", ERR_RID, err_m);
            @(posedge clk); #1;
            cyc++;
            if (rr) begin
                err_m |= bad;
                b++;
                d = (base != 0) ? base + b : $urandom;
                M_AXI_RDATA = d;
                M_AXI_RLAST = (b == len);
            end
            if (tog) rr = ~rr;
            REQ_RREADY[e] = rr;
            REQ_RREADY[1-e] = ~rr;
        end
        chk("beats_delivered", b, nsend);
        if (nsend == len + 1) begin
            M_AXI_RVALID = 1'b0;
            M_AXI_RLAST = 1'b0;
            REQ_RREADY = '1;
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        n_chk = 0; n_fail = 0; ptr_m = 0; err_m = 1'b0;
        rst = 1'b1;
        REQ_ARVALID = '0; REQ_RREADY = '1;
        addr_q[0] = 0; addr_q[1] = 0; len_q[0] = 0; len_q[1] = 0;
        M_AXI_ARREADY = 0; M_AXI_RID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 0; M_AXI_RVALID = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_ar_payload", {M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARID}, 0);
        chk("rst_err", ERR_RID, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_req_rvalid", REQ_RVALID, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // contention: both requesters held for three single-beat bursts
        addr_q[0] = $urandom; addr_q[1] = $urandom;
        REQ_ARVALID = 2'b11;
        for (int i = 0; i < 3; i++) begin
            grant_phase((i == 2) ? 2 : 0, g, ea, el);
            chk("contention_order", g, (i % 2));
            addr_phase(g, 0, ea, el);
            data_phase(g, 0, 1, 0, 0, 2'b00, 0);
        end
        // single request, 4 beats 0xA0..0xA3
        addr_q[0] = 32'h1000; len_q[0] = 8'd3;
        REQ_ARVALID = 2'b01;
        grant_phase(1, g, ea, el);
        addr_phase(g, 0, ea, el);
        data_phase(g, 3, 4, 0, 0, 2'b00, 32'hA0);
        // backpressure: 8 beats, toggling ready, ARREADY after 5 cycles
        addr_q[1] = $urandom; len_q[1] = 8'd7;
        REQ_ARVALID = 2'b10;
        grant_phase(1, g, ea, el);
        addr_phase(g, 5, ea, el);
        data_phase(g, 7, 8, 1, 0, 2'b00, 0);
        // reset after beat 2 of 8
        addr_q[0] = $urandom; len_q[0] = 8'd7;
        REQ_ARVALID = 2'b01;
        grant_phase(1, g, ea, el);
        addr_phase(g, 0, ea, el);
        data_phase(g, 7, 2, 0, 0, 2'b00, 0);
        #3 rst = 1'b1;
        #1;
        chk("midreset_arvalid", M_AXI_ARVALID, 0);
        chk("midreset_rready", M_AXI_RREADY, 0);
        chk("midreset_req_rvalid", REQ_RVALID, 0);
        M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; REQ_RREADY = '1;
        ptr_m = 0; err_m = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        // reset during the address phase
        REQ_ARVALID = 2'b11;
        grant_phase(2, g, ea, el);
        chk("post_reset_grant", g, 0);
        @(negedge clk);
        chk("arvalid_before_reset", M_AXI_ARVALID, 1);
        #2 rst = 1'b1;
        #1;
        chk("addr_reset_arvalid", M_AXI_ARVALID, 0);
        chk("addr_reset_araddr", M_AXI_ARADDR, 0);
        ptr_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        // RID mismatch with SLVERR on requester 1
        addr_q[1] = $urandom; len_q[1] = 8'd2;
        REQ_ARVALID = 2'b10;
        grant_phase(1, g, ea, el);
        addr_phase(g, 0, ea, el);
        data_phase(g, 2, 3, 0, 1, 2'b10, 0);
        chk("err_rid_set", err_m, 1);
        // randomized bursts
        for (int i = 0; i < 10; i++) begin
            addr_q[0] = $urandom; addr_q[1] = $urandom;
            len_q[0] = 8'($urandom_range(0, 5)); len_q[1] = 8'($urandom_range(0, 5));
            REQ_ARVALID = 2'($urandom_range(1, 3));
            grant_phase(2, g, ea, el);
            addr_phase(g, $urandom_range(0, 3), ea, el);
            data_phase(g, int'(el), int'(el) + 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), 0);
        end
        // stray beat while idle
        @(posedge clk); #1;
        M_AXI_RVALID = 1'b1; M_AXI_RLAST = 1'b1; REQ_RREADY = '1;
        repeat (3) begin
            @(negedge clk);
            idle_chk();
            chk("stray_arready", REQ_ARREADY, 0);
        end
        M_AXI_RVALID = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
